// File: rtl/mips16_pkg.sv
// mips16_pkg: shared widths and fetch constants for the 16-bit MIPS core
package mips16_pkg;
  localparam int INSTR_W = 16;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
  localparam int PC_STEP = 2;
endpackage

// File: rtl/mips16_fetch_queue.sv
// mips16_fetch_queue: slot buffer reserved at issue, filled in response order, popped by decode
import mips16_pkg::*;
module mips16_fetch_queue #(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               reserve_i,
  input  logic [ADDR_W-1:0]  reserve_pc_i,
  input  logic               fill_i,
  input  logic [INSTR_W-1:0] fill_data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic               head_valid_o,
  output logic [INSTR_W-1:0] head_instr_o,
  output logic [ADDR_W-1:0]  head_pc_o,
  output logic [CW-1:0]      free_o,
  output logic [CW-1:0]      unfilled_o
);
  logic [INSTR_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0]  pc_q [DEPTH];
  logic [DEPTH-1:0]   filled_q;
  logic [PW-1:0]      head_q, fill_q, tail_q;
  logic [CW-1:0]      count_q, unfilled_q;
  // A slot popped this cycle is already free for a new reservation, so a full buffer keeps streaming
  always_comb begin
    head_valid_o = filled_q[head_q];
    head_instr_o = data_q[head_q];
    head_pc_o = pc_q[head_q];
    free_o = CW'(DEPTH) - count_q + CW'(pop_i);
    unfilled_o = unfilled_q;
  end
  // Slot state: reserve at tail, fill at oldest unfilled, free at head; flush drops every slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i] <= '0;
      end
      filled_q <= '0;
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      unfilled_q <= '0;
    end else if (flush_i) begin
      filled_q <= '0;
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      unfilled_q <= '0;
    end else begin
      if (reserve_i) begin
        pc_q[tail_q] <= reserve_pc_i;
        filled_q[tail_q] <= 1'b0;
        tail_q <= tail_q + 1'b1;
      end
      if (fill_i) begin
        data_q[fill_q] <= fill_data_i;
        filled_q[fill_q] <= 1'b1;
        fill_q <= fill_q + 1'b1;
      end
      if (pop_i) begin
        filled_q[head_q] <= 1'b0;
        head_q <= head_q + 1'b1;
      end
      count_q <= count_q + CW'(reserve_i) - CW'(pop_i);
      unfilled_q <= unfilled_q + CW'(reserve_i) - CW'(fill_i);
    end
  end
endmodule

// File: rtl/mips16_fetch_unit.sv
// mips16_fetch_unit: PC, in-order imem requests, response squashing and hand-off to decode
import mips16_pkg::*;
module mips16_fetch_unit #(
  parameter logic [ADDR_W-1:0] RESET_PC = mips16_pkg::RESET_PC,
  parameter int PC_STEP = mips16_pkg::PC_STEP,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int DW = $clog2(2 * DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  pc_out
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     free, unfilled;
  logic              head_valid, reserve, fill, pop;
  mips16_fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .reserve_i    (reserve),
    .reserve_pc_i (pc_q),
    .fill_i       (fill),
    .fill_data_i  (imem_rsp_data),
    .pop_i        (pop),
    .flush_i      (redirect),
    .head_valid_o (head_valid),
    .head_instr_o (if_instr),
    .head_pc_o    (if_pc),
    .free_o       (free),
    .unfilled_o   (unfilled)
  );
  // Redirect silences issue and dequeue; responses owed to squashed requests are counted as drops
  always_comb begin
    imem_req_valid = !reset && !redirect && free != '0;
    imem_req_addr = pc_q;
    pc_out = pc_q;
    reserve = imem_req_valid && imem_req_ready;
    fill = imem_rsp_valid && drop_q == '0 && !redirect;
    if_valid = head_valid && !redirect;
    pop = if_valid && if_ready;
    pc_d = redirect ? redirect_pc : reserve ? pc_q + ADDR_W'(PC_STEP) : pc_q;
    drop_d = redirect ? drop_q + DW'(unfilled) - DW'(imem_rsp_valid)
                      : drop_q - DW'(imem_rsp_valid && drop_q != '0);
  end
  // PC and squash counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q <= pc_d;
      drop_q <= drop_d;
    end
  end
  a_rsp_expected: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (drop_q != '0 || unfilled != '0));
endmodule

// File: tb/tb_mips16_fetch_unit.sv
// tb_mips16_fetch_unit: directed checks of fetch streaming, backpressure, redirect squash, wrap and reset
module tb_mips16_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, imem_req_valid, imem_req_ready, imem_rsp_valid, redirect, if_valid, if_ready;
  logic [15:0] imem_req_addr, imem_rsp_data, redirect_pc, if_instr, if_pc, pc_out;
  typedef struct {logic [15:0] a; int due;} ent_t;
  ent_t        mq[$];
  int          n_assert = 0, n_fail = 0, cyc = 0, lat = 1, nreq = 0, npops = 0, n0, w, k;
  logic [15:0] exp_pc;

  mips16_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .pc_out         (pc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // one clock: sample handshakes, scoreboard any dequeue, then advance the in-order memory model
  task automatic tick();
    logic acc, rs;
    logic [15:0] ad;
    #1;
    acc = imem_req_valid && imem_req_ready;
    ad = imem_req_addr;
    rs = imem_rsp_valid;
    if (if_valid && if_ready) begin
      chk("pop_pc", 32'(if_pc), 32'(exp_pc));
      chk("pop_instr", 32'(if_instr), 32'(exp_pc ^ 16'hA5A5));
      exp_pc = exp_pc + 16'd2;
      npops++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) mq.delete();
    else begin
      if (rs && mq.size() > 0) mq.delete(0);
      if (acc) begin
        nreq++;
        mq.push_back('{ad, cyc + lat - 1});
      end
    end
    imem_rsp_valid = mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_data = mq.size() > 0 ? mq[0].a ^ 16'hA5A5 : 16'h0000;
  endtask

  task automatic do_redirect(input logic [15:0] p);
    redirect = 1'b1;
    redirect_pc = p;
    tick();
    redirect = 1'b0;
    exp_pc = p;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    #1;
    while (!if_valid && n < 20) begin
      tick();
      n++;
      #1;
    end
    chk("wait_valid", 32'(if_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 16'h0000;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    if_ready = 1'b0;
    exp_pc = 16'h0000;
    #100;
    chk("rst_pc_out", 32'(pc_out), 32'h0000);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_instr", 32'(if_instr), 32'h0000);
    chk("rst_if_pc", 32'(if_pc), 32'h0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", 32'(imem_req_addr), 32'h0000);
    if_ready = 1'b1;
    repeat (10) tick();
    chk("stream_pops", 32'(npops), 32'd8);
    chk("stream_next_pc", 32'(exp_pc), 32'h0010);
    if_ready = 1'b0;
    do_redirect(16'h0040);
    n0 = nreq;
    repeat (10) tick();
    #1;
    chk("bp_reqs", 32'(nreq - n0), 32'd2);
    chk("bp_pc_out", 32'(pc_out), 32'h0044);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    chk("bp_if_valid", 32'(if_valid), 32'd1);
    chk("bp_if_pc", 32'(if_pc), 32'h0040);
    chk("bp_if_instr", 32'(if_instr), 32'hA5E5);
    if_ready = 1'b1;
    n0 = npops;
    repeat (6) tick();
    chk("bp_release_pops", 32'(npops - n0), 32'd6);
    chk("bp_release_next", 32'(exp_pc), 32'h004C);
    lat = 3;
    do_redirect(16'h0080);
    repeat (2) tick();
    #1;
    chk("full_pc_out", 32'(pc_out), 32'h0084);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    do_redirect(16'h0100);
    wait_valid(w);
    chk("drop_wait", 32'(w), 32'd4);
    chk("drop_if_pc", 32'(if_pc), 32'h0100);
    chk("drop_if_instr", 32'(if_instr), 32'hA4A5);
    k = 0;
    while (!(imem_rsp_valid && if_valid) && k < 20) begin
      tick();
      k++;
      #1;
    end
    chk("rsp_and_valid", 32'(imem_rsp_valid && if_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    #1;
    chk("rr_if_valid", 32'(if_valid), 32'd0);
    chk("rr_req_valid", 32'(imem_req_valid), 32'd0);
    n0 = npops;
    tick();
    redirect = 1'b0;
    exp_pc = 16'hFFFE;
    #1;
    chk("rr_no_pop", 32'(npops - n0), 32'd0);
    chk("rr_pc_out", 32'(pc_out), 32'hFFFE);
    chk("rr_req_valid_next", 32'(imem_req_valid), 32'd1);
    chk("rr_req_addr", 32'(imem_req_addr), 32'hFFFE);
    wait_valid(w);
    chk("wrap_pc_fffe", 32'(if_pc), 32'hFFFE);
    tick();
    wait_valid(w);
    chk("wrap_pc_0000", 32'(if_pc), 32'h0000);
    chk("wrap_instr", 32'(if_instr), 32'hA5A5);
    reset = 1'b1;
    #1;
    chk("mid_rst_if_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_pc_out", 32'(pc_out), 32'h0000);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("mid_rst_if_instr", 32'(if_instr), 32'h0000);
    if_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", 32'(imem_req_addr), 32'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
